// File: rtl/uart_rx_arbiter.sv
// Round-robin arbiter that drains NCH UART receive FIFOs into one character stream,
// with an optional drop of errored words and per-channel saturating error counters.
module uart_rx_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 5,
    parameter int DW  = 11,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_en,
    input  logic              drop_err,
    input  logic              err_clr,
    input  logic [NCH*CW-1:0] rf_count,
    input  logic [NCH*DW-1:0] rf_data,
    output logic [NCH-1:0]    rf_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CHW-1:0]    out_ch,
    output logic [1:0]        out_err,
    output logic [NCH*8-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t         state_reg;
    logic [CHW-1:0] grant_reg;
    logic [CHW-1:0] last_reg;
    logic [NCH-1:0] pop_reg;
    logic           out_valid_reg;
    logic [7:0]     out_data_reg;
    logic [CHW-1:0] out_ch_reg;
    logic [1:0]     out_err_reg;
    logic [7:0]     err_cnt_reg [NCH];

    logic [NCH-1:0] elig;
    logic [DW-1:0]  head_word [NCH];
    logic [DW-1:0]  head;
    logic           head_err;
    logic           head_brk_unused;
    logic [CHW-1:0] pick;
    logic           found;

    // Word layout is {data[7:0], break, parity_err, framing_err}; break is not used here.
    assign head            = head_word[grant_reg];
    assign head_err        = head[1] | head[0];
    assign head_brk_unused = head[2];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign elig[gi]            = ch_en[gi] && (rf_count[gi*CW +: CW] != '0);
            assign head_word[gi]       = rf_data[gi*DW +: DW];
            assign err_cnt[gi*8 +: 8]  = err_cnt_reg[gi];

            // A clear in the same cycle as an increment wins.
            always_ff @(posedge clk) begin
                if (!rst_n || err_clr) begin
                    err_cnt_reg[gi] <= 8'd0;
                end else if (state_reg == S_POP && grant_reg == CHW'(gi) &&
                             head_err && err_cnt_reg[gi] != 8'hFF) begin
                    err_cnt_reg[gi] <= err_cnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    // Search last+1, last+2, ... wrapping, ending at last itself.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = last_reg;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_reg) + k) % NCH;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = CHW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            grant_reg     <= '0;
            last_reg      <= CHW'(NCH - 1);
            pop_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
            out_ch_reg    <= '0;
            out_err_reg   <= 2'd0;
        end else begin
            pop_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (found) begin
                        grant_reg <= pick;
                        last_reg  <= pick;
                        pop_reg   <= NCH'(1) << pick;
                        state_reg <= S_POP;
                    end
                end
                S_POP: begin
                    out_data_reg <= head[DW-1 -: 8];
                    out_err_reg  <= head[1:0];
                    out_ch_reg   <= grant_reg;
                    if (drop_err && head_err) begin
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg     <= S_OUT;
                        out_valid_reg <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // The pop strobe is masked while reset is held so no FIFO word is lost to a reset.
    assign rf_pop    = rst_n ? pop_reg : '0;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_err   = out_err_reg;

endmodule

// File: doc/uart_rx_arbiter.md
UART_RX_ARBITER -- requirements
Module: uart_rx_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of UART receiver channels served.
REQ-002 SHALL have parameter CW, default 5, meaning the width of each channel's FIFO count.
REQ-003 SHALL have parameter DW, default 11, meaning the width of a FIFO word: {data[7:0], break, parity_err, framing_err}.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning the reset, which is synchronous and active-low.
REQ-006 SHALL have port ch_en, input, NCH, meaning the per-channel service enable.
REQ-007 SHALL have port drop_err, input, 1, meaning that words carrying parity or framing errors are discarded after the pop.
REQ-008 SHALL have port err_clr, input, 1, meaning all error counters clear.
REQ-009 SHALL have port rf_count, input, NCH*CW, meaning the packed FIFO counts, with channel i at [i*CW +: CW].
REQ-010 SHALL have port rf_data, input, NCH*DW, meaning the packed FIFO head words; each head is valid combinationally while its count is non-zero.
REQ-011 SHALL have port rf_pop, output, NCH, meaning the one-cycle pop strobes.
REQ-012 SHALL have port out_valid, output, 1, meaning that the forwarded character is valid.
REQ-013 SHALL have port out_ready, input, 1, meaning that the downstream consumer accepts the character.
REQ-014 SHALL have port out_data, output, 8, meaning the received character.
REQ-015 SHALL have port out_ch, output, clog2(NCH), meaning the source channel index.
REQ-016 SHALL have port out_err, output, 2, meaning {parity_err, framing_err} of the forwarded word.
REQ-017 SHALL have port err_cnt, output, NCH*8, meaning the packed per-channel saturating error counters.

Function
REQ-018 SHALL implement the states S_IDLE, S_POP and S_OUT.
REQ-019 In S_IDLE, a channel SHALL be eligible when ch_en[i]=1 and rf_count[i]!=0.
REQ-020 In S_IDLE, the block SHALL search last+1, last+2, ... wrapping modulo NCH and ending at last, and grant the first eligible channel.
REQ-021 On a grant, the block SHALL latch the granted channel, set last to it, and move to S_POP in the next cycle.
REQ-022 If no channel is eligible, the block SHALL stay in S_IDLE.
REQ-023 In S_POP, rf_pop[grant] SHALL be 1 for exactly one cycle, with all other rf_pop bits 0.
REQ-024 In S_POP, rf_data of the granted channel SHALL be captured into the out_data, out_err and out_ch registers in the same cycle.
REQ-025 At most one rf_pop bit SHALL be high in any cycle, and never two consecutive pops to any channel.
REQ-026 From S_POP, if drop_err=1 and the captured parity_err or framing_err bit is 1, the block SHALL go to S_IDLE without asserting out_valid.
REQ-027 From S_POP in all other cases, the block SHALL go to S_OUT.
REQ-028 In S_OUT, out_valid SHALL be 1 and out_data, out_ch and out_err SHALL be held stable until a cycle with out_ready=1.
REQ-029 On the S_OUT cycle with out_ready=1, the block SHALL go to S_IDLE, and out_valid SHALL be 0 in the following cycle.
REQ-030 Minimum spacing between transfers SHALL be 3 cycles (S_IDLE, S_POP, S_OUT with out_ready=1).
REQ-031 Deasserting ch_en[grant] after the grant SHALL NOT abort the transaction in progress.
REQ-032 The break bit SHALL be ignored by this block.
REQ-033 In S_POP, err_cnt[grant] SHALL increment by 1 when the captured word has parity_err or framing_err set, independent of drop_err.
REQ-034 err_cnt SHALL saturate at 255 with no wrap-around.
REQ-035 When err_clr=1, all counters SHALL be 0 in the next cycle, and err_clr SHALL win over a same-cycle increment (that increment is lost).
REQ-036 err_clr SHALL NOT affect the state machine or the round-robin pointer.
REQ-037 Any state encoding not listed SHALL return to S_IDLE in the next cycle.

Reset
REQ-038 When rst_n=0 at a clock edge, the block SHALL enter S_IDLE, with rf_pop=0, out_valid=0, out_data=0, out_ch=0, out_err=0, err_cnt all 0 and last=NCH-1, so channel 0 has the highest priority after reset.
REQ-039 Reset in S_OUT SHALL discard the captured character; the popped word is not replayed.
REQ-040 rf_pop SHALL be 0 during any cycle in which rst_n=0.

Verification
REQ-041 The bench SHALL cover: after reset, rf_count=1 on all 4 channels and out_ready=1 -> grants in order ch0, ch1, ch2, ch3, one rf_pop each, out_valid every 3rd cycle.
REQ-042 The bench SHALL cover: ch2 head word 0x55 with parity_err=1, drop_err=0, out_ready held 0 for 5 cycles -> out_data=0x55 and out_err=2'b10 stable for 5 cycles, err_cnt[2]=1, a single pop.
REQ-043 The bench SHALL cover: the same errored word with drop_err=1 -> pop occurs, out_valid stays 0, err_cnt[2] increments, next grant proceeds from ch3.
REQ-044 The bench SHALL cover: 300 framing-error words on ch1 -> err_cnt[1]=255; err_clr asserted in the same cycle as an increment -> 0.
REQ-045 The bench SHALL cover: rst_n=0 while in S_OUT -> next cycle out_valid=0 and state S_IDLE; next grant goes to the lowest eligible channel starting from ch0.
REQ-046 The bench SHALL cover: ch_en=4'b1010 with all counts non-zero -> only ch1 and ch3 are popped, alternating.
